seq_decoder: RTL and testbench
==============================

# seq_decoder

Registered, parametrised binary-to-vector decoder with a valid/ready handshake on both sides and a persistent mask register. It is the next generation of the team's 2-to-4 decoder. It adds generic select width, thermometer decoding, sticky set/clear mask modes, out-of-range detection and back-pressure. It sits between a command source and any consumer of one-hot or thermometer enables, such as bank selects or lane enables.

## Interface
- SEL_W, 2, select width in bits; legal range 1..6.
- OUT_W, 2**SEL_W, output vector width; legal range 1..2**SEL_W. A select value ≥ OUT_W is out of range.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- sel  in  SEL_W  binary select.
- en  in  1  decode enable; 0 forces a zero decode.
- mode  in  2  00 one-hot, 01 thermometer, 10 mask-set, 11 mask-clear.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out  out  OUT_W  decoded vector.
- err  out  1  the result came from an out-of-range sel.

## Operation
- **Transfer:** a request transfers on the rising edge when in_valid && in_ready. sel, en and mode are sampled only at a transfer.
- **Decode vector D:**
  - D = 0 if en=0 or sel ≥ OUT_W.
  - Otherwise D = 1<<sel.
- **Result per mode, registered into out:**
  - 00: out = D.
  - 01: out = bits [sel:0] set, all others 0. Zero if en=0 or out of range.
  - 10: mask ← mask | D; out = new mask.
  - 11: mask ← mask & ~D; out = new mask.
- **Mask register:** OUT_W bits, internal. It changes only on a mode 10/11 transfer. Modes 00/01 leave it untouched.
- **Errors:**
  - err = 1 when sel ≥ OUT_W and en = 1, at the transfer that produced the result.
  - On an error the mask is unchanged.
  - err is never set when en = 0.
- **Output register:** one stage holding out, err and out_valid.
  - in_ready = !out_valid || out_ready (combinational).
  - A transfer sets out_valid = 1 next cycle.
  - out_valid drops when out_ready = 1 and no new transfer occurs that cycle.
- **Simultaneous output drain and input transfer:** the new result replaces the old one and out_valid stays 1. There are no bubbles and no losses.
- **Stall:** while out_valid && !out_ready, out and err hold stable and in_ready = 0.
- **Mask-mode hazard:** back-to-back mask operations see each other's effect with no hazard. The mask updates at the same edge as out.

## Timing
- **Latency:** 1 cycle from transfer edge to out_valid/out/err.
- **Throughput:** 1 request per cycle while out_ready = 1.
- **Reset, asynchronous and immediate on rst_n low:**
  - out = 0, err = 0, out_valid = 0, mask = 0.
  - in_ready = 1 (derived).
  - No transfer is recorded on the edge where rst_n deasserts while clk is low. The first transfer is possible on the first rising edge with rst_n high.
- **Reset mid-operation:** a pending unconsumed result is discarded and the mask is cleared. The consumer must not expect the result.
- **Handshake stability:** the source holds sel, en and mode stable while in_valid && !in_ready. Same-cycle stability on the output side is guaranteed by the block.
- **Mode boundary cases:**
  - Thermometer with sel = OUT_W-1 gives all ones.
  - Mask-set on an already-set bit, and mask-clear on an already-clear bit, are no-ops that still produce a result.

## Test plan
- **One-hot sweep** (defaults, out_ready = 1, mode 00, en = 1): sel 0..3 on consecutive cycles -> out 0001, 0010, 0100, 1000 one cycle later each; out_valid stays 1; err = 0.
- **Thermometer and enable** (mode 01): sel = 2 -> out 0111; sel = 3 -> 1111; sel = 1 with en = 0 -> 0000, err = 0.
- **Mask modes:**
  - Sequence (10, sel 0), (10, sel 3), (11, sel 0), (10, sel 3) -> out 0001, 1001, 1000, 1000.
  - Then assert rst_n = 0 mid-stream -> out = 0, out_valid = 0, mask = 0.
  - Then (10, sel 1) -> out 0010.
- **Back-pressure:**
  - Hold out_ready = 0 after one transfer (sel 2, mode 00) -> out_valid = 1, out = 0100, in_ready = 0 for 3 cycles, and a changed sel is ignored.
  - Raise out_ready with in_valid = 1, sel 1 -> next cycle out = 0010 with no gap.
- **Out of range** (SEL_W = 2, OUT_W = 3): mask = 011 via sets, then (10, sel 3) -> out 011, err = 1.
- **Out of range, one-hot and disabled** (same instance): (00, sel 3) -> out 000, err = 1. With en = 0 -> err = 0.

Source files
------------

// File: rtl/seq_decoder.sv
// seq_decoder: registered binary-to-vector decoder with valid/ready on both
// sides. Supports one-hot, thermometer, and sticky mask set/clear modes,
// flags out-of-range selects, and holds its result under back-pressure.
module seq_decoder #(
    parameter int SEL_W = 2,
    parameter int OUT_W = 2 ** SEL_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic             err
);

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'b00,
        MODE_THERM  = 2'b01,
        MODE_SET    = 2'b10,
        MODE_CLEAR  = 2'b11
    } mode_e;

    logic [OUT_W-1:0] mask;
    logic [OUT_W-1:0] dec;
    logic [OUT_W-1:0] therm;
    logic [OUT_W-1:0] result;
    logic [31:0]      sel_wide;
    logic             in_range;
    logic             err_next;
    logic             xfer;

    // The output stage can accept a new request when empty or draining this cycle.
    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;
    assign sel_wide = 32'(sel);
    assign in_range = sel_wide < 32'(OUT_W);
    assign err_next = en && !in_range;

    // Build the one-hot and thermometer vectors; both are zero when disabled or out of range.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        dec   = '0;
        therm = '0;
        for (int i = 0; i < OUT_W; i++) begin
            dec[i]   = en && in_range && (sel_wide == 32'(i));
            therm[i] = en && in_range && (32'(i) <= sel_wide);
        end
    end

    // Select the result for the requested mode; mask modes fold the decode into the current mask.
    always_comb begin
        result = dec;
        case (mode_e'(mode))
            MODE_ONEHOT: result = dec;
            MODE_THERM:  result = therm;
            MODE_SET:    result = mask | dec;
            MODE_CLEAR:  result = mask & ~dec;
            default:     result = dec;
        endcase
    end

    // Output register and mask update; a transfer loads a new result, a drain without transfer empties the stage.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            out_valid <= 1'b0;
            out       <= '0;
            err       <= 1'b0;
            mask      <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out       <= result;
            err       <= err_next;
            // An out-of-range select yields a zero decode, so the mask is naturally left unchanged.
            if (mode[1]) begin
                mask <= result;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_decoder.sv
// Testbench for seq_decoder: a default instance (SEL_W=2, OUT_W=4) and a
// narrow instance (SEL_W=2, OUT_W=3) for out-of-range cases. Expected results
// are queued at each transfer and popped by a monitor on every output handshake.
module tb_seq_decoder;

    typedef struct packed {
        logic [3:0] out;
        logic       err;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [1:0] sel_v     [2];
    logic       en_v      [2];
    logic [1:0] mode_v    [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [3:0] out_v     [2];
    logic       err_v     [2];
    logic [2:0] out_b;

    exp_t exp_q [2][$];
    int   checks;
    int   failures;

    seq_decoder #(.SEL_W(2), .OUT_W(4)) dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .sel       (sel_v[0]),
        .en        (en_v[0]),
        .mode      (mode_v[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out       (out_v[0]),
        .err       (err_v[0])
    );

    seq_decoder #(.SEL_W(2), .OUT_W(3)) dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .sel       (sel_v[1]),
        .en        (en_v[1]),
        .mode      (mode_v[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out       (out_b),
        .err       (err_v[1])
    );

    assign out_v[1] = {1'b0, out_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Present one request on instance k and queue its hand-computed result at the transfer.
    task automatic send(input int k, input logic [1:0] m, input logic [1:0] s, input logic e,
                        input logic [3:0] exp_out, input logic exp_err);
        int n;
        in_valid[k] = 1'b1;
        sel_v[k]    = s;
        en_v[k]     = e;
        mode_v[k]   = m;
        n = 0;
        while (!in_ready[k] && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready[k]) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid[k] = 1'b0;
            return;
        end
        exp_q[k].push_back({exp_out, exp_err});
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
    endtask

    // Monitor: every output handshake pops and compares the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (rst_n && out_valid[k] && out_ready[k]) begin
                if (exp_q[k].size() == 0) begin
                    check(k == 0 ? "a_unexpected_output" : "b_unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q[k].pop_front();
                    check(k == 0 ? "a_out" : "b_out", 32'(out_v[k]), 32'(e.out));
                    check(k == 0 ? "a_err" : "b_err", 32'(err_v[k]), 32'(e.err));
                end
            end
        end
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            sel_v[k]     = '0;
            en_v[k]      = 1'b0;
            mode_v[k]    = '0;
            out_ready[k] = 1'b1;
        end

        // Reset state
        #1;
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_out", 32'(out_v[0]), 32'd0);
        check("rst_err", 32'(err_v[0]), 32'd0);
        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // One-hot sweep on consecutive cycles
        send(0, 2'b00, 2'd0, 1'b1, 4'b0001, 1'b0);
        send(0, 2'b00, 2'd1, 1'b1, 4'b0010, 1'b0);
        check("sweep_valid", 32'(out_valid[0]), 32'd1);
        send(0, 2'b00, 2'd2, 1'b1, 4'b0100, 1'b0);
        check("sweep_valid", 32'(out_valid[0]), 32'd1);
        send(0, 2'b00, 2'd3, 1'b1, 4'b1000, 1'b0);
        check("sweep_valid", 32'(out_valid[0]), 32'd1);

        // Thermometer and enable
        send(0, 2'b01, 2'd2, 1'b1, 4'b0111, 1'b0);
        send(0, 2'b01, 2'd3, 1'b1, 4'b1111, 1'b0);
        send(0, 2'b01, 2'd1, 1'b0, 4'b0000, 1'b0);

        // Mask modes, including a clear of an already-clear bit
        send(0, 2'b10, 2'd0, 1'b1, 4'b0001, 1'b0);
        send(0, 2'b10, 2'd3, 1'b1, 4'b1001, 1'b0);
        send(0, 2'b11, 2'd0, 1'b1, 4'b1000, 1'b0);
        send(0, 2'b10, 2'd3, 1'b1, 4'b1000, 1'b0);
        send(0, 2'b11, 2'd0, 1'b1, 4'b1000, 1'b0);

        // Leave a result pending, then reset mid-stream; the pending result is discarded
        out_ready[0] = 1'b0;
        send(0, 2'b10, 2'd1, 1'b1, 4'b1010, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_q[0].delete();
        check("midrst_out_valid", 32'(out_valid[0]), 32'd0);
        check("midrst_out", 32'(out_v[0]), 32'd0);
        check("midrst_in_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        // Cleared mask: only the newly set bit appears
        send(0, 2'b10, 2'd1, 1'b1, 4'b0010, 1'b0);

        // Back-pressure: stall for 3 cycles with a changed sel that must be ignored
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        send(0, 2'b00, 2'd2, 1'b1, 4'b0100, 1'b0);
        in_valid[0] = 1'b1;
        sel_v[0]    = 2'd3;
        for (int c = 0; c < 3; c++) begin
            check("stall_out_valid", 32'(out_valid[0]), 32'd1);
            check("stall_out", 32'(out_v[0]), 32'b0100);
            check("stall_in_ready", 32'(in_ready[0]), 32'd0);
            @(posedge clk);
            #1;
        end
        sel_v[0]     = 2'd1;
        out_ready[0] = 1'b1;
        exp_q[0].push_back({4'b0010, 1'b0});
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        check("nogap_out_valid", 32'(out_valid[0]), 32'd1);
        check("nogap_out", 32'(out_v[0]), 32'b0010);

        // Out of range on the OUT_W=3 instance
        send(1, 2'b10, 2'd0, 1'b1, 4'b0001, 1'b0);
        send(1, 2'b10, 2'd1, 1'b1, 4'b0011, 1'b0);
        send(1, 2'b10, 2'd3, 1'b1, 4'b0011, 1'b1);
        send(1, 2'b10, 2'd0, 1'b1, 4'b0011, 1'b0);
        send(1, 2'b01, 2'd2, 1'b1, 4'b0111, 1'b0);
        send(1, 2'b00, 2'd3, 1'b1, 4'b0000, 1'b1);
        send(1, 2'b00, 2'd3, 1'b0, 4'b0000, 1'b0);

        // Let outstanding results drain, bounded
        n = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("a_missing_results", 32'(exp_q[0].size()), 32'd0);
        check("b_missing_results", 32'(exp_q[1].size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
